dma_csr: RTL and testbench

MMIO control/status front end for the `dma` block. It decodes CCI-P MMIO writes into DMA configuration registers: read address, write address, read length and write length. It sequences each transfer with a `begin_again` flush pulse, snapshots the configuration into the DMA-facing outputs for the duration of the run, and times the run. Status, the cycle count and the AFU device feature header (DFH) and AFU ID registers are returned on CCI-P channel c2. It sits between the AFU's `sRx` MMIO path and the `from_afu` config fields and `finished` flag of `dma`.

---
 rtl/dma_csr_pkg.sv | 90 +++++++++
 rtl/dma_csr.sv | 203 ++++++++++++++++++++
 tb/tb_dma_csr.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_csr_pkg.sv
// Shared types and constants for the DMA MMIO control/status front end.
// Pure declarations; no timing of its own.
// No flow control of its own.
package dma_csr_pkg;

  // Minimal CCI-P type subset used by the CSR block.
  typedef logic [41:0]  t_ccip_clAddr;
  typedef logic [15:0]  t_ccip_mmioAddr;
  typedef logic [8:0]   t_ccip_tid;
  typedef logic [511:0] t_ccip_clData;
  typedef logic [63:0]  t_ccip_mmioData;

  typedef struct packed {
    t_ccip_mmioAddr address;
    logic [1:0]     length;
    logic           rsvd;
    t_ccip_tid      tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    t_ccip_c0_ReqMmioHdr hdr;
    t_ccip_clData        data;
    logic                rspValid;
    logic                mmioRdValid;
    logic                mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c0_Rx c0;
  } t_if_ccip_Rx;

  typedef struct packed {
    t_ccip_tid tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    t_ccip_mmioData      data;
  } t_if_ccip_c2_Tx;

  // hdr.length encoding for MMIO requests: 0 = 4B, 1 = 8B, 2 = 64B.
  localparam logic [1:0] MMIO_LEN_8B = 2'b01;

  // DWORD register map.
  localparam t_ccip_mmioAddr ADDR_DFH      = 16'h0000;
  localparam t_ccip_mmioAddr ADDR_AFU_ID_L = 16'h0002;
  localparam t_ccip_mmioAddr ADDR_AFU_ID_H = 16'h0004;
  localparam t_ccip_mmioAddr ADDR_RSVD0    = 16'h0006;
  localparam t_ccip_mmioAddr ADDR_RSVD1    = 16'h0008;
  localparam t_ccip_mmioAddr ADDR_RD_ADDR  = 16'h0020;
  localparam t_ccip_mmioAddr ADDR_WR_ADDR  = 16'h0022;
  localparam t_ccip_mmioAddr ADDR_RD_LEN   = 16'h0024;
  localparam t_ccip_mmioAddr ADDR_WR_LEN   = 16'h0026;
  localparam t_ccip_mmioAddr ADDR_CTRL     = 16'h0028;
  localparam t_ccip_mmioAddr ADDR_STATUS   = 16'h002A;
  localparam t_ccip_mmioAddr ADDR_CYCLES   = 16'h002C;

  localparam logic [63:0] DFH_VALUE = 64'h1000_0100_0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } t_csr_state;

  // STATUS register bit positions.
  localparam int STS_BUSY      = 0;
  localparam int STS_DONE      = 1;
  localparam int STS_START_REJ = 2;
  localparam int STS_BAD_CFG   = 3;
  localparam int STS_STATE_LSB = 4;

  function automatic logic [63:0] status_word(input t_csr_state st,
                                              input logic       start_rej,
                                              input logic       bad_cfg);
    logic [63:0] w;
    w = '0;
    w[STS_BUSY]             = (st == FLUSH) || (st == RUN);
    w[STS_DONE]             = (st == DONE);
    w[STS_START_REJ]        = start_rej;
    w[STS_BAD_CFG]          = bad_cfg;
    w[STS_STATE_LSB +: 2]   = st;
    return w;
  endfunction

endpackage

// File: rtl/dma_csr.sv
// MMIO CSR front end for the DMA: config registers, flush/run sequencing, run timer.
// Read response one cycle after the request; writes visible on the next cycle.
// No backpressure: every MMIO request is accepted, one response per read.
module dma_csr
  import dma_csr_pkg::*;
#(
  parameter logic [63:0] AFU_ID_L     = 64'h0,
  parameter logic [63:0] AFU_ID_H     = 64'h0,
  parameter int unsigned FLUSH_CYCLES = 4    // legal range 1..15
) (
  input  logic           clk,
  input  logic           soft_reset,
  input  t_if_ccip_Rx    sRx,
  output t_if_ccip_c2_Tx mmio_c2,
  output t_ccip_clAddr   dma_rd_addr,
  output t_ccip_clAddr   dma_wr_addr,
  output logic [64:0]    dma_rd_len,
  output logic [64:0]    dma_wr_len,
  output logic           begin_again,
  input  logic           dma_finished
);

  localparam int          AW         = $bits(t_ccip_clAddr);
  localparam logic [3:0]  FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  // Request decode
  t_ccip_mmioAddr req_addr;
  logic [63:0]    wr_data;
  logic           wr_en;
  logic           start_wr;

  assign req_addr = sRx.c0.hdr.address;
  assign wr_data  = sRx.c0.data[63:0];
  assign wr_en    = sRx.c0.mmioWrValid && (sRx.c0.hdr.length == MMIO_LEN_8B);
  assign start_wr = wr_en && (req_addr == ADDR_CTRL) && wr_data[0];

  // Fields of the Rx bundle this block never looks at.
  logic unused_rx;
  assign unused_rx = ^{sRx.c0TxAlmFull, sRx.c1TxAlmFull, sRx.c0.rspValid,
                       sRx.c0.hdr.rsvd, sRx.c0.data[511:64]};

  // Configuration registers
  t_ccip_clAddr rd_addr_q, wr_addr_q;
  logic [63:0]  rd_len_q, wr_len_q;

  // Run-side state
  t_csr_state   state_q, state_d;
  logic [3:0]   flush_cnt_q, flush_cnt_d;
  logic [63:0]  cycles_q;
  logic         start_rej_q, bad_cfg_q;
  t_ccip_clAddr dma_rd_addr_q, dma_wr_addr_q;
  logic [63:0]  dma_rd_len_q, dma_wr_len_q;

  // FSM strobes
  logic accept_start, bad_start, reject_start, enter_run;

  // Response path
  t_if_ccip_c2_Tx rsp_q, rsp_d;
  logic [63:0]    rd_data;

  // Config registers take 8-byte writes to their own even address only.
  always_ff @(posedge clk) begin
    if (soft_reset) begin
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      rd_len_q  <= '0;
      wr_len_q  <= '0;
    end else if (wr_en) begin
      case (req_addr)
        ADDR_RD_ADDR: rd_addr_q <= wr_data[AW-1:0];
        ADDR_WR_ADDR: wr_addr_q <= wr_data[AW-1:0];
        ADDR_RD_LEN:  rd_len_q  <= wr_data;
        ADDR_WR_LEN:  wr_len_q  <= wr_data;
        default: ;
      endcase
    end
  end

  // Sequencer next-state: start qualification, flush countdown, run end.
  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    accept_start = 1'b0;
    bad_start    = 1'b0;
    reject_start = 1'b0;
    enter_run    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_wr) begin
          if ((rd_addr_q != '0) && (wr_addr_q != '0)) begin
            state_d      = FLUSH;
            flush_cnt_d  = '0;
            accept_start = 1'b1;
          end else begin
            bad_start = 1'b1;
          end
        end
      end
      FLUSH: begin
        reject_start = start_wr;
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d   = RUN;
          enter_run = 1'b1;
        end else begin
          flush_cnt_d = flush_cnt_q + 4'd1;
        end
      end
      RUN: begin
        reject_start = start_wr;
        if (dma_finished) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (soft_reset) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // DMA-facing snapshot, run timer and sticky status bits.
  always_ff @(posedge clk) begin
    if (soft_reset) begin
      dma_rd_addr_q <= '0;
      dma_wr_addr_q <= '0;
      dma_rd_len_q  <= '0;
      dma_wr_len_q  <= '0;
      cycles_q      <= '0;
      start_rej_q   <= 1'b0;
      bad_cfg_q     <= 1'b0;
    end else begin
      // Outputs read as zero for the whole flush window.
      if (accept_start) begin
        dma_rd_addr_q <= '0;
        dma_wr_addr_q <= '0;
        dma_rd_len_q  <= '0;
        dma_wr_len_q  <= '0;
        start_rej_q   <= 1'b0;
      end
      if (reject_start) start_rej_q <= 1'b1;
      if (bad_start)    bad_cfg_q   <= 1'b1;
      if (enter_run) begin
        dma_rd_addr_q <= rd_addr_q;
        dma_wr_addr_q <= wr_addr_q;
        dma_rd_len_q  <= rd_len_q;
        dma_wr_len_q  <= wr_len_q;
        cycles_q      <= '0;
        bad_cfg_q     <= 1'b0;
      end else if ((state_q == RUN) && (cycles_q != '1)) begin
        cycles_q <= cycles_q + 64'd1;
      end
    end
  end

  // Read mux over pre-edge register state; holes and odd addresses read 0.
  always_comb begin
    rd_data = '0;
    case (req_addr)
      ADDR_DFH:      rd_data = DFH_VALUE;
      ADDR_AFU_ID_L: rd_data = AFU_ID_L;
      ADDR_AFU_ID_H: rd_data = AFU_ID_H;
      ADDR_RSVD0:    rd_data = '0;
      ADDR_RSVD1:    rd_data = '0;
      ADDR_RD_ADDR:  rd_data = 64'(rd_addr_q);
      ADDR_WR_ADDR:  rd_data = 64'(wr_addr_q);
      ADDR_RD_LEN:   rd_data = rd_len_q;
      ADDR_WR_LEN:   rd_data = wr_len_q;
      ADDR_STATUS:   rd_data = status_word(state_q, start_rej_q, bad_cfg_q);
      ADDR_CYCLES:   rd_data = cycles_q;
      default:       rd_data = '0;
    endcase
  end

  // Every read of any size gets exactly one response with its tid.
  always_comb begin
    rsp_d = '0;
    if (sRx.c0.mmioRdValid) begin
      rsp_d.mmioRdValid = 1'b1;
      rsp_d.hdr.tid     = sRx.c0.hdr.tid;
      rsp_d.data        = rd_data;
    end
  end

  // Registered response, one cycle after the request.
  always_ff @(posedge clk) begin
    if (soft_reset) rsp_q <= '0;
    else            rsp_q <= rsp_d;
  end

  assign mmio_c2     = rsp_q;
  assign begin_again = (state_q == FLUSH);
  assign dma_rd_addr = dma_rd_addr_q;
  assign dma_wr_addr = dma_wr_addr_q;
  assign dma_rd_len  = {1'b0, dma_rd_len_q};
  assign dma_wr_len  = {1'b0, dma_wr_len_q};

endmodule

// File: tb/tb_dma_csr.sv
// Self-checking bench for dma_csr against a transaction-level reference model.
// Model effects are applied per clock edge from the bench's own stimulus.
// Model keeps registers, sticky bits, symbolic state and a flush countdown.
module tb_dma_csr;
  import dma_csr_pkg::*;

  localparam int unsigned FC   = 4;
  localparam logic [63:0] ID_L = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] ID_H = 64'hFEDC_BA98_7654_3210;
  localparam int S_IDLE = 0, S_FLUSH = 1, S_RUN = 2, S_DONE = 3;

  logic           clk = 1'b0;
  logic           soft_reset;
  t_if_ccip_Rx    sRx;
  t_if_ccip_c2_Tx mmio_c2;
  t_ccip_clAddr   dma_rd_addr, dma_wr_addr;
  logic [64:0]    dma_rd_len, dma_wr_len;
  logic           begin_again, dma_finished;

  always #5 clk = ~clk;

  dma_csr #(.AFU_ID_L(ID_L), .AFU_ID_H(ID_H), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .soft_reset(soft_reset), .sRx(sRx), .mmio_c2(mmio_c2),
    .dma_rd_addr(dma_rd_addr), .dma_wr_addr(dma_wr_addr),
    .dma_rd_len(dma_rd_len), .dma_wr_len(dma_wr_len),
    .begin_again(begin_again), .dma_finished(dma_finished)
  );

  int vectors, errors;

  // Reference model state
  logic [41:0] m_rd_addr, m_wr_addr, m_dra, m_dwa;
  logic [63:0] m_rd_len, m_wr_len, m_drl, m_dwl, m_cycles;
  int          m_state, m_flush_left;
  logic        m_rej, m_bad;
  logic        exp_vld;
  logic [63:0] exp_data;
  logic [8:0]  exp_tid;

  function automatic void model_reset();
    m_rd_addr = '0; m_wr_addr = '0; m_rd_len = '0; m_wr_len = '0;
    m_dra = '0; m_dwa = '0; m_drl = '0; m_dwl = '0; m_cycles = '0;
    m_state = S_IDLE; m_flush_left = 0; m_rej = 1'b0; m_bad = 1'b0;
  endfunction

  function automatic logic [63:0] model_read(input logic [15:0] a);
    logic [63:0] s;
    s = '0;
    case (a)
      16'h0000: s = 64'h1000_0100_0000_0000;
      16'h0002: s = ID_L;
      16'h0004: s = ID_H;
      16'h0020: s = {22'b0, m_rd_addr};
      16'h0022: s = {22'b0, m_wr_addr};
      16'h0024: s = m_rd_len;
      16'h0026: s = m_wr_len;
      16'h002A: s = 64'(m_state) * 16 + (m_bad ? 8 : 0) + (m_rej ? 4 : 0)
                    + ((m_state == S_DONE) ? 2 : 0)
                    + ((m_state == S_FLUSH || m_state == S_RUN) ? 1 : 0);
      16'h002C: s = m_cycles;
      default:  s = '0;
    endcase
    return s;
  endfunction

  // Apply one clock edge: predict response and model effects, then step.
  task automatic tick();
    logic [15:0] a;
    logic [63:0] d;
    logic        wr, start;
    a = sRx.c0.hdr.address;
    d = sRx.c0.data[63:0];
    exp_vld  = sRx.c0.mmioRdValid && !soft_reset;
    exp_tid  = sRx.c0.hdr.tid;
    exp_data = exp_vld ? model_read(a) : 64'h0;
    if (soft_reset) begin
      model_reset();
    end else begin
      wr    = sRx.c0.mmioWrValid && (sRx.c0.hdr.length == 2'd1);
      start = wr && (a == 16'h0028) && d[0];
      case (m_state)
        S_IDLE, S_DONE: if (start) begin
          if (m_rd_addr != 0 && m_wr_addr != 0) begin
            m_state = S_FLUSH; m_flush_left = FC; m_rej = 1'b0;
            m_dra = '0; m_dwa = '0; m_drl = '0; m_dwl = '0;
          end else m_bad = 1'b1;
        end
        S_FLUSH: begin
          if (start) m_rej = 1'b1;
          m_flush_left = m_flush_left - 1;
          if (m_flush_left == 0) begin
            m_state = S_RUN; m_cycles = '0; m_bad = 1'b0;
            m_dra = m_rd_addr; m_dwa = m_wr_addr; m_drl = m_rd_len; m_dwl = m_wr_len;
          end
        end
        default: begin
          if (start) m_rej = 1'b1;
          if (m_cycles != 64'hFFFF_FFFF_FFFF_FFFF) m_cycles = m_cycles + 1;
          if (dma_finished) m_state = S_DONE;
        end
      endcase
      if (wr) begin
        case (a)
          16'h0020: m_rd_addr = d[41:0];
          16'h0022: m_wr_addr = d[41:0];
          16'h0024: m_rd_len  = d;
          16'h0026: m_wr_len  = d;
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic mmio_write(input logic [15:0] a, input logic [63:0] d, input logic [1:0] len);
    sRx = '0;
    sRx.c0.mmioWrValid    = 1'b1;
    sRx.c0.hdr.address    = a;
    sRx.c0.hdr.length     = len;
    sRx.c0.data           = {16{$urandom}};
    sRx.c0.data[63:0]     = d;
    tick();
    sRx = '0;
  endtask

  task automatic mmio_read(input logic [15:0] a, input logic [8:0] tid,
                           output logic v, output logic [63:0] d, output logic [8:0] t);
    sRx = '0;
    sRx.c0.mmioRdValid = 1'b1;
    sRx.c0.hdr.address = a;
    sRx.c0.hdr.length  = 2'd1;
    sRx.c0.hdr.tid     = tid;
    tick();
    sRx = '0;
    v = mmio_c2.mmioRdValid;
    d = mmio_c2.data;
    t = mmio_c2.hdr.tid;
  endtask

  task automatic test_reset();
    logic v; logic [63:0] d; logic [8:0] t;
    soft_reset = 1'b1;
    tick(); tick();
    soft_reset = 1'b0;
    vectors++;
    if (begin_again !== 1'b0 || mmio_c2 !== '0 || dma_rd_addr !== '0 || dma_wr_len !== '0) begin
      errors++;
      $display("FAIL reset_outputs: begin_again=%b rdvld=%b dma_rd_addr=%h dma_wr_len=%h, want all 0",
               begin_again, mmio_c2.mmioRdValid, dma_rd_addr, dma_wr_len);
    end
    mmio_read(16'h002A, 9'd1, v, d, t);
    vectors++;
    if (v !== 1'b1 || d !== 64'h0) begin
      errors++; $display("FAIL reset_status: vld=%b data=%h, want vld=1 data=0", v, d);
    end
  endtask

  task automatic test_identity();
    logic v; logic [63:0] d; logic [8:0] t;
    logic [15:0] addrs [5];
    logic [63:0] want  [5];
    addrs = '{16'h0000, 16'h0002, 16'h0004, 16'h0030, 16'h0006};
    want  = '{64'h1000_0100_0000_0000, ID_L, ID_H, 64'h0, 64'h0};
    for (int i = 0; i < 5; i++) begin
      mmio_read(addrs[i], 9'd5, v, d, t);
      vectors++;
      if (v !== 1'b1 || d !== want[i] || t !== 9'd5) begin
        errors++;
        $display("FAIL identity_%h: vld=%b data=%h tid=%0d, want vld=1 data=%h tid=5",
                 addrs[i], v, d, t, want[i]);
      end
    end
    tick();
    vectors++;
    if (mmio_c2.mmioRdValid !== 1'b0) begin
      errors++; $display("FAIL rsp_one_cycle: vld=%b, want 0", mmio_c2.mmioRdValid);
    end
  endtask

  task automatic test_normal_start();
    logic v; logic [63:0] d; logic [8:0] t;
    mmio_write(16'h0020, 64'h1000, 2'd1);
    mmio_write(16'h0022, 64'h2000, 2'd1);
    mmio_write(16'h0024, 64'd8, 2'd1);
    mmio_write(16'h0026, 64'd8, 2'd1);
    mmio_read(16'h0020, 9'd7, v, d, t);
    vectors++;
    if (d !== 64'h1000 || t !== 9'd7) begin
      errors++; $display("FAIL rd_addr_readback: data=%h tid=%0d, want 1000 tid=7", d, t);
    end
    mmio_write(16'h0028, 64'h1, 2'd1);
    for (int i = 0; i < FC; i++) begin
      vectors++;
      if (begin_again !== 1'b1 || dma_rd_addr !== '0 || dma_rd_len !== '0) begin
        errors++;
        $display("FAIL flush_cycle_%0d: begin_again=%b dma_rd_addr=%h dma_rd_len=%h, want 1/0/0",
                 i, begin_again, dma_rd_addr, dma_rd_len);
      end
      tick();
    end
    vectors++;
    if (begin_again !== 1'b0 || dma_rd_addr !== 42'h1000 || dma_wr_addr !== 42'h2000 ||
        dma_rd_len !== 65'd8 || dma_wr_len !== 65'd8) begin
      errors++;
      $display("FAIL run_snapshot: ba=%b ra=%h wa=%h rl=%h wl=%h, want 0/1000/2000/8/8",
               begin_again, dma_rd_addr, dma_wr_addr, dma_rd_len, dma_wr_len);
    end
    repeat (19) tick();
    dma_finished = 1'b1;
    tick();
    dma_finished = 1'b0;
    mmio_read(16'h002A, 9'd2, v, d, t);
    vectors++;
    if (d !== 64'h32) begin
      errors++; $display("FAIL done_status: data=%h, want 32", d);
    end
    mmio_read(16'h002C, 9'd3, v, d, t);
    vectors++;
    if (d !== 64'd20) begin
      errors++; $display("FAIL run_cycles: data=%0d, want 20", d);
    end
  endtask

  task automatic test_midrun_reconfig();
    logic v; logic [63:0] d; logic [8:0] t;
    mmio_write(16'h0028, 64'h1, 2'd1);
    repeat (FC) tick();
    mmio_write(16'h0020, 64'h5000, 2'd1);
    mmio_write(16'h0028, 64'h1, 2'd1);
    mmio_read(16'h002A, 9'd4, v, d, t);
    vectors++;
    if (d !== 64'h25 || dma_rd_addr !== 42'h1000) begin
      errors++;
      $display("FAIL midrun_reject: status=%h dma_rd_addr=%h, want 25 / 1000", d, dma_rd_addr);
    end
    mmio_read(16'h0020, 9'd4, v, d, t);
    vectors++;
    if (d !== 64'h5000) begin
      errors++; $display("FAIL midrun_cfg_write: data=%h, want 5000", d);
    end
    dma_finished = 1'b1;
    tick();
    dma_finished = 1'b0;
    mmio_read(16'h002C, 9'd4, v, d, t);
    vectors++;
    if (d !== 64'd5) begin
      errors++; $display("FAIL midrun_cycles: data=%0d, want 5", d);
    end
    mmio_read(16'h002A, 9'd4, v, d, t);
    vectors++;
    if (d !== 64'h36) begin
      errors++; $display("FAIL sticky_reject: status=%h, want 36", d);
    end
  endtask

  task automatic test_zero_addr();
    logic v; logic [63:0] d; logic [8:0] t;
    int seen;
    soft_reset = 1'b1; tick(); soft_reset = 1'b0;
    mmio_write(16'h0020, 64'h1000, 2'd1);
    mmio_write(16'h0022, 64'h0, 2'd1);
    mmio_write(16'h0028, 64'h1, 2'd1);
    seen = 0;
    for (int i = 0; i < FC + 2; i++) begin
      if (begin_again !== 1'b0) seen++;
      tick();
    end
    mmio_read(16'h002A, 9'd9, v, d, t);
    vectors++;
    if (seen != 0 || d !== 64'h08) begin
      errors++; $display("FAIL zero_addr: begin_again cycles=%0d status=%h, want 0 / 08", seen, d);
    end
  endtask

  task automatic test_reset_midflush();
    logic v; logic [63:0] d; logic [8:0] t;
    logic [15:0] regs [6];
    regs = '{16'h0020, 16'h0022, 16'h0024, 16'h0026, 16'h002A, 16'h002C};
    mmio_write(16'h0020, 64'h3000, 2'd1);
    mmio_write(16'h0022, 64'h4000, 2'd1);
    mmio_write(16'h0024, 64'h40, 2'd1);
    mmio_write(16'h0028, 64'h1, 2'd1);
    tick();
    vectors++;
    if (begin_again !== 1'b1) begin
      errors++; $display("FAIL second_flush_cycle: begin_again=%b, want 1", begin_again);
    end
    soft_reset = 1'b1; tick(); soft_reset = 1'b0;
    vectors++;
    if (begin_again !== 1'b0 || mmio_c2 !== '0 || dma_rd_addr !== '0) begin
      errors++;
      $display("FAIL midflush_reset: begin_again=%b rdvld=%b dma_rd_addr=%h, want 0/0/0",
               begin_again, mmio_c2.mmioRdValid, dma_rd_addr);
    end
    for (int i = 0; i < 6; i++) begin
      mmio_read(regs[i], 9'(i), v, d, t);
      vectors++;
      if (v !== 1'b1 || d !== 64'h0) begin
        errors++; $display("FAIL reset_reg_%h: vld=%b data=%h, want vld=1 data=0", regs[i], v, d);
      end
    end
  endtask

  task automatic test_non8_write();
    logic v; logic [63:0] d; logic [8:0] t;
    mmio_write(16'h0020, 64'h7000, 2'd1);
    mmio_write(16'h0020, 64'h9000, 2'd0);
    mmio_write(16'h0020, 64'hA000, 2'd2);
    mmio_write(16'h0021, 64'hB000, 2'd1);
    mmio_write(16'h002A, 64'hFF, 2'd1);
    mmio_read(16'h0020, 9'd11, v, d, t);
    vectors++;
    if (d !== 64'h7000) begin
      errors++; $display("FAIL non8_write: data=%h, want 7000", d);
    end
    mmio_read(16'h0021, 9'd12, v, d, t);
    vectors++;
    if (v !== 1'b1 || d !== 64'h0 || t !== 9'd12) begin
      errors++; $display("FAIL odd_read: vld=%b data=%h tid=%0d, want 1/0/12", v, d, t);
    end
    mmio_read(16'h002A, 9'd13, v, d, t);
    vectors++;
    if (d !== 64'h0) begin
      errors++; $display("FAIL ro_status_write: data=%h, want 0", d);
    end
  endtask

  task automatic test_back_to_back();
    logic v; logic [63:0] d; logic [8:0] t;
    mmio_write(16'h0026, 64'hDEAD_BEEF_0000_1234, 2'd1);
    mmio_read(16'h0026, 9'h1A0, v, d, t);
    vectors++;
    if (v !== 1'b1 || d !== 64'hDEAD_BEEF_0000_1234 || t !== 9'h1A0) begin
      errors++; $display("FAIL b2b_wr_then_rd: vld=%b data=%h tid=%h", v, d, t);
    end
    mmio_read(16'h0004, 9'h1A1, v, d, t);
    vectors++;
    if (v !== 1'b1 || d !== ID_H || t !== 9'h1A1) begin
      errors++; $display("FAIL b2b_second: vld=%b data=%h tid=%h, want 1/%h/1a1", v, d, t, ID_H);
    end
  endtask

  task automatic test_random();
    logic [15:0] rd_tbl [14];
    logic [15:0] wr_tbl [7];
    int op;
    rd_tbl = '{16'h00, 16'h02, 16'h04, 16'h06, 16'h08, 16'h20, 16'h21, 16'h22,
               16'h24, 16'h26, 16'h28, 16'h2A, 16'h2C, 16'h30};
    wr_tbl = '{16'h20, 16'h22, 16'h24, 16'h26, 16'h21, 16'h2A, 16'h2C};
    soft_reset = 1'b1; tick(); soft_reset = 1'b0;
    for (int i = 0; i < 600; i++) begin
      op = int'($urandom_range(0, 9));
      sRx = '0;
      sRx.c0.data = {16{$urandom}};
      dma_finished = ($urandom_range(0, 9) == 0);
      if (op <= 3) begin
        sRx.c0.mmioRdValid = 1'b1;
        sRx.c0.hdr.address = rd_tbl[$urandom_range(0, 13)];
        sRx.c0.hdr.length  = 2'($urandom_range(0, 2));
        sRx.c0.hdr.tid     = 9'($urandom);
      end else if (op <= 6) begin
        sRx.c0.mmioWrValid = 1'b1;
        sRx.c0.hdr.address = wr_tbl[$urandom_range(0, 6)];
        sRx.c0.hdr.length  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'd1;
        if ($urandom_range(0, 3) == 0) sRx.c0.data[63:0] = 64'h0;
      end else if (op == 7) begin
        sRx.c0.mmioWrValid = 1'b1;
        sRx.c0.hdr.address = 16'h0028;
        sRx.c0.hdr.length  = 2'd1;
      end
      tick();
      sRx = '0;
      dma_finished = 1'b0;
      vectors++;
      if (mmio_c2.mmioRdValid !== exp_vld ||
          (exp_vld && (mmio_c2.data !== exp_data || mmio_c2.hdr.tid !== exp_tid))) begin
        errors++;
        $display("FAIL rand_rsp[%0d]: vld=%b data=%h tid=%h, want vld=%b data=%h tid=%h",
                 i, mmio_c2.mmioRdValid, mmio_c2.data, mmio_c2.hdr.tid, exp_vld, exp_data, exp_tid);
      end
      vectors++;
      if (begin_again !== (m_state == S_FLUSH) || dma_rd_addr !== m_dra || dma_wr_addr !== m_dwa ||
          dma_rd_len !== {1'b0, m_drl} || dma_wr_len !== {1'b0, m_dwl}) begin
        errors++;
        $display("FAIL rand_dma[%0d]: ba=%b ra=%h wa=%h rl=%h wl=%h, want %b %h %h %h %h",
                 i, begin_again, dma_rd_addr, dma_wr_addr, dma_rd_len, dma_wr_len,
                 (m_state == S_FLUSH), m_dra, m_dwa, m_drl, m_dwl);
      end
    end
  endtask

  initial begin
    vectors = 0;
    errors = 0;
    soft_reset = 1'b1;
    dma_finished = 1'b0;
    sRx = '0;
    model_reset();
    test_reset();
    test_identity();
    test_normal_start();
    test_midrun_reconfig();
    test_zero_addr();
    test_reset_midflush();
    test_non8_write();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
